// File: rtl/instruction_mem.sv
// instruction_mem: loadable program memory with a registered, stallable fetch port
// Ports:
//   clk, resetN        - clock and asynchronous active-low reset
//   loadStart          - begin a program load at address 0 (IDLE or RUN)
//   loadValid/loadData - load word handshake with loadReady; loadLast marks the final word
//   loadCount          - words written in the current or most recent load
//   fetchReq, stall    - fetch request and output-stage hold
//   programCounter     - fetch address
//   machineCode        - registered fetched word, fetchValid marks a fresh result
//   addrFault          - result came from an address at or beyond DEPTH (returns NOP)
module instruction_mem #(
    parameter int W = 9,
    parameter int D = 12,
    parameter int DEPTH = 2**D,
    parameter logic [W-1:0] NOP = '0
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         loadStart,
    input  logic         loadValid,
    input  logic [W-1:0] loadData,
    input  logic         loadLast,
    output logic         loadReady,
    output logic [D:0]   loadCount,
    input  logic         fetchReq,
    input  logic         stall,
    input  logic [D-1:0] programCounter,
    output logic [W-1:0] machineCode,
    output logic         fetchValid,
    output logic         addrFault
);
    localparam logic [D:0] LIMIT = (D+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t state, state_nx;
    logic [W-1:0] mem [DEPTH];
    logic xfer, enter_load, fetch, fault;
    logic [D:0] count_nx;

    assign loadReady = (state == LOAD);

    always_comb begin
        xfer = (state == LOAD) && loadValid;
        count_nx = loadCount + 1'b1;
        enter_load = (state != LOAD) && loadStart;
        // a reprogram request in RUN wins over a same-cycle fetch
        fetch = (state == RUN) && fetchReq && !loadStart;
        fault = {1'b0, programCounter} >= LIMIT;
        state_nx = state;
        if (enter_load)
            state_nx = LOAD;
        else if (xfer && (loadLast || count_nx == LIMIT))
            state_nx = RUN;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            loadCount   <= '0;
            machineCode <= '0;
            fetchValid  <= 1'b0;
            addrFault   <= 1'b0;
        end else begin
            state <= state_nx;
            if (enter_load)
                loadCount <= '0;
            else if (xfer)
                loadCount <= count_nx;
            if (!stall) begin
                fetchValid <= fetch;
                if (fetch) begin
                    machineCode <= fault ? NOP : mem[programCounter];
                    addrFault   <= fault;
                end
            end
        end
    end

    // contents survive reset, so the array has no reset branch
    always_ff @(posedge clk)
        if (xfer)
            mem[loadCount[D-1:0]] <= loadData;
endmodule

// File: doc/instruction_mem.md
INSTRUCTION_MEM -- requirements
Module: instruction_mem

Interface
REQ-001 SHALL have parameter W, default 9: instruction word width in bits.
REQ-002 SHALL have parameter D, default 12: address width in bits.
REQ-003 SHALL have parameter DEPTH, default 2**D: number of implemented words, legal range 1..2**D.
REQ-004 SHALL have parameter NOP, default all-zero W bits: word returned for out-of-range fetches.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port resetN, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port loadStart, input, 1 bit: request to begin a program load at address 0.
REQ-008 SHALL have port loadValid, input, 1 bit: loadData holds a valid word.
REQ-009 SHALL have port loadData, input, W bits: program word to write.
REQ-010 SHALL have port loadLast, input, 1 bit: the current load word is the final one.
REQ-011 SHALL have port loadReady, output, 1 bit: block accepts a load word this cycle.
REQ-012 SHALL have port loadCount, output, D+1 bits: number of words written in the current or most recent load.
REQ-013 SHALL have port fetchReq, input, 1 bit: fetch request.
REQ-014 SHALL have port stall, input, 1 bit: hold the fetch output stage.
REQ-015 SHALL have port programCounter, input, D bits: fetch address.
REQ-016 SHALL have port machineCode, output, W bits: registered fetched word.
REQ-017 SHALL have port fetchValid, output, 1 bit: machineCode holds a fresh fetch result.
REQ-018 SHALL have port addrFault, output, 1 bit: the current result came from an address >= DEPTH.

Function
REQ-019 SHALL implement an FSM with states IDLE, LOAD and RUN.
REQ-020 IDLE SHALL go to LOAD on loadStart; otherwise it stays in IDLE.
REQ-021 On entry to LOAD, loadCount SHALL clear to 0.
REQ-022 loadReady SHALL be 1 only in LOAD.
REQ-023 A transfer SHALL occur when loadValid=1 and loadReady=1.
REQ-024 Each transfer SHALL write loadData to word loadCount and increment loadCount by 1.
REQ-025 LOAD SHALL go to RUN after a transfer with loadLast=1, or after the transfer that makes loadCount equal DEPTH, whichever comes first.
REQ-026 loadStart SHALL be ignored while in LOAD.
REQ-027 In RUN, loadStart SHALL go to LOAD (reprogram); a fetch request in that same cycle SHALL be ignored.
REQ-028 In IDLE and LOAD, fetchReq SHALL be ignored, fetchValid SHALL be 0, and machineCode SHALL hold its value.
REQ-029 Fetch latency SHALL be 1 cycle: in RUN with fetchReq=1 and stall=0, on the next edge machineCode = word[programCounter] and fetchValid=1.
REQ-030 If programCounter >= DEPTH, the fetch SHALL return NOP with addrFault=1; otherwise addrFault=0.
REQ-031 While stall=1, machineCode, fetchValid and addrFault SHALL all hold, in every state.
REQ-032 In RUN with fetchReq=0 and stall=0, fetchValid SHALL be 0 and machineCode and addrFault SHALL hold.
REQ-033 A fetch SHALL never observe a write in the same cycle, because loading and fetching are exclusive by state.
REQ-034 Words never written since power-up SHALL read as undefined; the bench SHALL not check them.

Reset
REQ-035 When resetN=0, state SHALL become IDLE immediately, asynchronously to clk.
REQ-036 During reset, machineCode=0, fetchValid=0, addrFault=0, loadReady=0 and loadCount=0.
REQ-037 Memory contents SHALL be retained through reset.
REQ-038 A reset in the middle of a load SHALL abort it; words already written stay written.
REQ-039 After resetN rises, the block SHALL remain in IDLE until loadStart.

Verification (W=9, D=4, DEPTH=12, NOP=0)
REQ-040 Load 001111110, 001100110, 001111010 with loadLast on the third word, then fetch PC 0,1,2 -> each word appears one cycle after its request with fetchValid=1 and loadCount=3.
REQ-041 Load 12 words with loadLast never asserted -> RUN is entered after the 12th transfer with loadCount=12 and loadReady=0 in the next cycle.
REQ-042 Fetch PC=13 -> machineCode=000000000 and addrFault=1; next fetch PC=0 -> addrFault=0.
REQ-043 Fetch PC=1, assert stall for 3 cycles while PC changes to 2 -> machineCode=001100110 and fetchValid=1 held for all 3 cycles; after release, PC=2 result arrives 1 cycle later.
REQ-044 Pull resetN low after 2 of 5 load words -> outputs zero immediately and IDLE; after loadStart plus a full reload, fetches return the new data.
REQ-045 Reprogram in RUN: loadStart with fetchReq both high -> no fetch result follows, loadCount=0, and fetches after the reload return the new words.
